// File: rtl/tpsram_wconv_fifo_if.sv
// tpsram_wconv_fifo_if: write/read/status bundle for the width-converting FIFO
//   master: w_en, w_data, r_en, clr_err out; flags, levels, r_data, r_valid in
//   slave : the reverse, used by the FIFO itself
interface tpsram_wconv_fifo_if #(
  parameter int W_WIDTH = 64,
  parameter int R_WIDTH = 8,
  parameter int W_DEPTH = 512
);
  localparam int R_DEPTH = W_DEPTH * (W_WIDTH / R_WIDTH);
  logic                       w_en;
  logic [W_WIDTH-1:0]         w_data;
  logic                       full;
  logic                       afull;
  logic                       r_en;
  logic [R_WIDTH-1:0]         r_data;
  logic                       r_valid;
  logic                       empty;
  logic [$clog2(W_DEPTH):0]   w_level;
  logic [$clog2(R_DEPTH):0]   r_level;
  logic                       overflow;
  logic                       underflow;
  logic                       clr_err;
  modport master (
    output w_en, w_data, r_en, clr_err,
    input  full, afull, r_data, r_valid, empty, w_level, r_level, overflow, underflow
  );
  modport slave (
    input  w_en, w_data, r_en, clr_err,
    output full, afull, r_data, r_valid, empty, w_level, r_level, overflow, underflow
  );
endinterface

// File: rtl/tpsram_wconv_fifo.sv
// tpsram_wconv_fifo: single-clock FIFO taking W_WIDTH words, returning R_WIDTH lanes LSB-first
//   clk   : rising-edge clock
//   rst_n : active-low reset, asserted asynchronously, released in sync with clk
//   bus   : slave side of tpsram_wconv_fifo_if (write request/data, read request,
//           registered read lane + valid, full/afull/empty, levels, sticky errors)
module tpsram_wconv_fifo #(
  parameter int W_WIDTH      = 64,
  parameter int R_WIDTH      = 8,
  parameter int W_DEPTH      = 512,
  parameter int AFULL_THRESH = 448
) (
  input logic               clk,
  input logic               rst_n,
  tpsram_wconv_fifo_if.slave bus
);
  localparam int RATIO = W_WIDTH / R_WIDTH;
  localparam int LB    = $clog2(RATIO);
  localparam int WA    = $clog2(W_DEPTH);
  localparam int RA    = WA + LB;

  if (RATIO < 1 || RATIO * R_WIDTH != W_WIDTH || (RATIO & (RATIO - 1)) != 0 ||
      W_DEPTH < 2 || (W_DEPTH & (W_DEPTH - 1)) != 0) begin : g_bad_params
    $error("tpsram_wconv_fifo: RATIO and W_DEPTH must be powers of 2");
  end

  logic [1:0]         rst_sync;
  logic               rst_i_n;
  logic [WA:0]        wptr;
  logic [RA:0]        rptr;
  logic [RA:0]        r_level;
  logic [RA+1:0]      lsum;
  logic [WA:0]        w_level;
  logic [W_WIDTH-1:0] mem [W_DEPTH];
  logic [W_WIDTH-1:0] word;
  logic [R_WIDTH-1:0] lane;
  logic               wr;
  logic               rd;

  // Assertion passes straight through; release waits two clocks.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i_n = rst_sync[1];

  // Write pointer scaled to lanes; the wrap bits make the subtraction mod 2*R_DEPTH.
  // A partially read word still holds its slot, hence the round-up for w_level.
  always_comb begin
    r_level = ((RA+1)'(wptr) << LB) - rptr;
    lsum    = {1'b0, r_level} + (RA+2)'(RATIO - 1);
    w_level = (WA+1)'(lsum >> LB);
    wr      = bus.w_en & ~bus.full;
    rd      = bus.r_en & ~bus.empty;
    word    = mem[WA'(rptr[RA-1:0] >> LB)];
    // With RATIO==1 the mask is zero and the shift folds away.
    lane    = R_WIDTH'(word >> (R_WIDTH * int'(rptr[RA-1:0] & RA'(RATIO - 1))));
  end

  assign bus.r_level = r_level;
  assign bus.w_level = w_level;
  assign bus.full    = w_level == (WA+1)'(W_DEPTH);
  assign bus.empty   = r_level == '0;
  assign bus.afull   = 32'(w_level) >= AFULL_THRESH;

  always_ff @(posedge clk)
    if (wr) mem[wptr[WA-1:0]] <= bus.w_data;

  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      wptr          <= '0;
      rptr          <= '0;
      bus.r_data    <= '0;
      bus.r_valid   <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr       <= rptr + 1'b1;
        bus.r_data <= lane;
      end
      bus.r_valid   <= rd;
      bus.overflow  <= (bus.w_en & bus.full) | (bus.overflow & ~bus.clr_err);
      bus.underflow <= (bus.r_en & bus.empty) | (bus.underflow & ~bus.clr_err);
    end
endmodule

// File: doc/tpsram_wconv_fifo.md
Name: tpsram_wconv_fifo

Overview:
- Parametrised width-converting FIFO: accepts wide words on the write side and delivers narrow lanes on the read side, in lane order LSB-first.
- Generalises the fixed 512x64-write / 4096x8-read two-port SRAM to configurable width, ratio and depth.
- Adds pointer management, full/empty/almost-full flags, level counts and sticky error flags.
- Sits between wide datapath producers, such as 64-bit packet assembly, and byte-serial consumers, all on one clock domain.

Parameters:
W_WIDTH, 64, write word width in bits
R_WIDTH, 8, read lane width in bits; RATIO = W_WIDTH/R_WIDTH is a power of 2 and >= 1
W_DEPTH, 512, storage depth in write words (power of 2); R_DEPTH = W_DEPTH*RATIO
AFULL_THRESH, 448, AFULL asserts when W_LEVEL >= this value

Ports:
CLK  input  1  single clock, rising edge
RESET_N  input  1  reset; asynchronous assert, active-low, release synchronised to CLK
W_EN  input  1  write request
W_DATA  input  W_WIDTH  write word; lane k = W_DATA[(k+1)*R_WIDTH-1 : k*R_WIDTH]
FULL  output  1  no free write-word slot
AFULL  output  1  W_LEVEL >= AFULL_THRESH
R_EN  input  1  read request, one lane
R_DATA  output  R_WIDTH  read lane, registered
R_VALID  output  1  R_DATA holds a newly read lane
EMPTY  output  1  no unread lane
W_LEVEL  output  clog2(W_DEPTH)+1  occupied write-word slots
R_LEVEL  output  clog2(R_DEPTH)+1  unread lanes
OVERFLOW  output  1  sticky: write attempted while FULL
UNDERFLOW  output  1  sticky: read attempted while EMPTY
CLR_ERR  input  1  clears OVERFLOW and UNDERFLOW

Behaviour:
- Reset, asynchronous: write pointer, read pointer, R_DATA, R_VALID, OVERFLOW and UNDERFLOW all = 0. EMPTY=1, FULL=0, AFULL=0 (AFULL_THRESH > 0), W_LEVEL=0, R_LEVEL=0.
- Reset mid-operation discards all contents. Memory array contents are not reset and are never observable until rewritten.
- Pointers:
  - wptr is a clog2(W_DEPTH)+1-bit wide-word pointer with a wrap bit.
  - rptr is a clog2(R_DEPTH)+1-bit lane pointer with a wrap bit.
  - Read address = rptr low bits; lane select = rptr[clog2(RATIO)-1:0]. This matches a memory viewed as {word_addr, lane}.
- Levels, all combinational from registered pointers:
  - R_LEVEL = (wptr*RATIO - rptr) mod 2*R_DEPTH.
  - W_LEVEL = ceil(R_LEVEL/RATIO). A partially read word still occupies its slot.
  - FULL = (W_LEVEL == W_DEPTH). EMPTY = (R_LEVEL == 0).
- Write: when W_EN=1 and FULL=0 at a rising edge, W_DATA is stored at wptr and wptr increments. With W_EN=1 and FULL=1: nothing is stored, the pointer is unchanged, and OVERFLOW is set.
- Read: when R_EN=1 and EMPTY=0 at edge N, R_DATA is updated with the lane at rptr after edge N (1-cycle latency), R_VALID=1 for that cycle, and rptr increments. With R_EN=1 and EMPTY=1: UNDERFLOW is set, R_VALID=0, and R_DATA holds its previous value.
- R_VALID=0 in any cycle without an accepted read. R_DATA holds its value between reads.
- Simultaneous write and read: both are evaluated against the flags from before the edge.
  - A write while FULL is rejected even if the same-cycle read frees a slot.
  - A read while EMPTY is rejected even if the same-cycle write fills a word.
  - Both pointers update in the same cycle.
- Write-to-read: a word written at edge N is readable from edge N+1. The read address never equals the address written in the same cycle, so no read-during-write hazard exists.
- Slot freeing: a write-word slot is freed when its last lane (lane RATIO-1) is read. FULL deasserts the cycle after that read.
- Wrap-around: pointers wrap naturally. The wrap bit distinguishes full from empty; no special-case logic.
- Error flags:
  - CLR_ERR=1 clears both flags at the edge.
  - If a new error occurs in the same cycle as CLR_ERR, the set wins.
- RATIO=1 degenerates to a plain FIFO; lane select logic is removed.
- Illegal parameters (RATIO not a power of 2, W_DEPTH not a power of 2) are caught by an elaboration-time check.

Test Plan:
- Reset, then write 0x0706050403020100; issue 8 consecutive R_EN -> R_DATA = 00,01,...,07 on consecutive cycles, each one cycle after its R_EN, with R_VALID=1. EMPTY=1 after the 8th read; R_LEVEL goes 8->0.
- Write 512 words -> FULL=1, W_LEVEL=512, R_LEVEL=4096, AFULL=1 from W_LEVEL=448. One read -> FULL stays 1, R_LEVEL=4095. After 8 reads -> FULL=0, W_LEVEL=511.
- Hold FULL and apply W_EN with 0xDEAD -> OVERFLOW=1 and the level is unchanged. Drain -> 0xDEAD is never read. CLR_ERR -> OVERFLOW=0.
- R_EN while EMPTY -> UNDERFLOW=1, R_VALID=0, R_DATA unchanged. Apply CLR_ERR together with another empty read -> UNDERFLOW stays 1.
- 3000 random write/read cycles with pointer wrap -> read stream equals a reference byte queue, and levels match the model every cycle.
- Assert RESET_N=0 asynchronously with 100 words stored -> flags and levels reset immediately without waiting for a clock edge. After release, EMPTY=1 and the first read sets UNDERFLOW.
